// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      CALC = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

   // Every quotient bit is forced to this value on a zero divisor.
   localparam bit DIVZ_Q_BIT = 1'b1;

   function automatic int unsigned count_width(input int unsigned dw);
      return $clog2(dw + 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor magnitude.
module div_step #(
   parameter int unsigned VW = 14
) (
   input  logic [VW:0]   rem_in,
   input  logic          bit_in,
   input  logic [VW-1:0] divisor_mag,
   output logic [VW:0]   rem_out,
   output logic          q_bit
);

   localparam int unsigned RW = VW + 1;
   localparam int unsigned SW = VW + 2;

   logic [SW-1:0] shifted;
   logic [RW-1:0] trial;

   always_comb begin
      shifted = {rem_in, bit_in};
      q_bit   = (shifted >= SW'(divisor_mag));
      trial   = RW'(shifted - SW'(divisor_mag));
      rem_out = q_bit ? trial : shifted[RW-1:0];
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned integer divider with valid/ready handshakes on both sides.
module seq_divider
   import div_pkg::*;
#(
   parameter int unsigned DW        = 26,
   parameter int unsigned VW        = 14,
   parameter bit          SIGNED_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   input  logic          signed_mode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero,
   output logic          busy
);

   localparam int unsigned CW = count_width(DW);

   state_t        state;
   logic [DW-1:0] work;
   logic [VW-1:0] div_reg;
   logic [VW:0]   prem;
   logic [CW-1:0] count;
   logic          eff_signed;
   logic          q_neg;
   logic          r_neg;
   logic [VW:0]   prem_nxt;
   logic          q_bit;

   div_step #(.VW(VW)) u_step (
      .rem_in      (prem),
      .bit_in      (work[DW-1]),
      .divisor_mag (div_reg),
      .rem_out     (prem_nxt),
      .q_bit       (q_bit)
   );

   // work holds the dividend and fills with quotient bits from the LSB as it shifts out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         work        <= '0;
         div_reg     <= '0;
         prem        <= '0;
         count       <= '0;
         eff_signed  <= 1'b0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         in_ready    <= 1'b1;
         busy        <= 1'b0;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work       <= dividend;
                  div_reg    <= divisor;
                  eff_signed <= signed_mode & SIGNED_EN;
                  in_ready   <= 1'b0;
                  busy       <= 1'b1;
                  state      <= PREP;
               end
            end
            PREP: begin
               if (div_reg == '0) begin
                  quotient    <= {DW{DIVZ_Q_BIT}};
                  remainder   <= work[VW-1:0];
                  div_by_zero <= 1'b1;
                  state       <= DONE;
               end else begin
                  work    <= (eff_signed && work[DW-1]) ? -work : work;
                  div_reg <= (eff_signed && div_reg[VW-1]) ? -div_reg : div_reg;
                  q_neg   <= eff_signed & (work[DW-1] ^ div_reg[VW-1]);
                  r_neg   <= eff_signed & work[DW-1];
                  prem    <= '0;
                  count   <= '0;
                  state   <= CALC;
               end
            end
            CALC: begin
               work  <= {work[DW-2:0], q_bit};
               prem  <= prem_nxt;
               count <= count + CW'(1);
               if (count == CW'(DW - 1)) state <= FIX;
            end
            FIX: begin
               quotient    <= q_neg ? -work : work;
               remainder   <= r_neg ? -prem[VW-1:0] : prem[VW-1:0];
               div_by_zero <= 1'b0;
               out_valid   <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               // The zero-divisor path arrives with out_valid low and raises it here.
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed corner cases plus randomized operands with backpressure.
module tb_seq_divider;

   localparam int unsigned DW = 26;
   localparam int unsigned VW = 14;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] dividend = '0;
   logic [VW-1:0] divisor = '0;
   logic          signed_mode = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_by_zero;
   logic          busy;

   typedef struct {
      logic [DW-1:0] q;
      logic [VW-1:0] r;
      logic          dbz;
      int unsigned   acc;
      int unsigned   lat;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   bit          bp_rand = 1'b0;
   logic        or_hold = 1'b1;

   seq_divider #(.DW(DW), .VW(VW), .SIGNED_EN(1'b1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .signed_mode (signed_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp_v, cyc);
      end
   endtask

   // Reference: plain integer division in the selected interpretation.
   function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b, input logic s);
      exp_t   e;
      longint sa, dv, q, r;
      e.acc = 0;
      e.dbz = 1'b0;
      e.lat = DW + 2;
      if (b == '0) begin
         e.q   = '1;
         e.r   = a[VW-1:0];
         e.dbz = 1'b1;
         e.lat = 2;
      end else begin
         sa = longint'(a);
         dv = longint'(b);
         if (s) begin
            if (a[DW-1]) sa = sa - (longint'(1) <<< DW);
            if (b[VW-1]) dv = dv - (longint'(1) <<< VW);
         end
         q   = sa / dv;
         r   = sa % dv;
         e.q = q[DW-1:0];
         e.r = r[VW-1:0];
      end
      return e;
   endfunction

   task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b, input logic s);
      exp_t e;
      int   n;
      @(negedge clk);
      dividend    = a;
      divisor     = b;
      signed_mode = s;
      in_valid    = 1'b1;
      n = 0;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout in_ready=%0b required=1", in_ready);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      e     = model(a, b, s);
      e.acc = cyc;
      sb.push_back(e);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", sb.size(), 0);
   endtask

   // Consumer side: out_ready changes just after the rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         out_ready = bp_rand ? ($urandom_range(0, 2) != 0) : or_hold;
      end
   end

   // Monitor: compare each new result, and check that held results stay stable.
   initial begin
      exp_t          e;
      logic          prev_valid;
      logic [DW-1:0] pq;
      logic [VW-1:0] pr;
      logic          pz;
      prev_valid = 1'b0;
      pq = '0;
      pr = '0;
      pz = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_valid = 1'b0;
         end else begin
            if (out_valid && !prev_valid) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious_result quotient=%0h required=no result", quotient);
               end else begin
                  e = sb.pop_front();
                  chk("quotient", quotient, e.q);
                  chk("remainder", remainder, e.r);
                  chk("div_by_zero", div_by_zero, e.dbz);
                  chk("latency", cyc - e.acc, e.lat);
               end
            end else if (out_valid) begin
               chk("hold_quotient", quotient, pq);
               chk("hold_remainder", remainder, pr);
               chk("hold_div_by_zero", div_by_zero, pz);
            end
            if (out_valid) chk("in_ready_while_valid", in_ready, 0);
            prev_valid = out_valid;
            pq = quotient;
            pr = remainder;
            pz = div_by_zero;
         end
      end
   end

   initial begin
      logic [DW-1:0] a;
      logic [VW-1:0] b;
      logic          s;
      int            n;

      repeat (3) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_div_by_zero", div_by_zero, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);

      issue(DW'(41254912), VW'(2891), 1'b0);
      issue(DW'(-100), VW'(7), 1'b1);
      issue(DW'(-100), VW'(-7), 1'b1);
      issue(DW'(1234), VW'(0), 1'b0);
      issue(DW'(32'h200_0000), VW'(16'h3FFF), 1'b1);
      issue(DW'(32'h200_0000), VW'(16'h3FFF), 1'b0);
      wait_drain();

      // Backpressure: hold the result, offer an operand that must be ignored.
      or_hold = 1'b0;
      repeat (2) @(negedge clk);
      issue(DW'(5000), VW'(13), 1'b0);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_out_valid_seen", out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         dividend = DW'(777);
         divisor  = VW'(3);
         in_valid = 1'b1;
         chk("bp_in_ready", in_ready, 0);
         chk("bp_busy", busy, 1);
         chk("bp_out_valid", out_valid, 1);
      end
      in_valid = 1'b0;
      or_hold  = 1'b1;
      @(posedge clk);
      #3;
      @(posedge clk);
      #1;
      chk("bp_release_in_ready", in_ready, 1);
      chk("bp_release_out_valid", out_valid, 0);
      issue(DW'(100), VW'(7), 1'b0);
      wait_drain();

      // Asynchronous reset in the middle of an operation.
      issue(DW'(12345), VW'(67), 1'b0);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_quotient", quotient, 0);
      chk("arst_remainder", remainder, 0);
      chk("arst_div_by_zero", div_by_zero, 0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("arst_in_ready", in_ready, 1);
      issue(DW'(100), VW'(7), 1'b0);
      wait_drain();

      // Randomized operands with random consumer stalls.
      bp_rand = 1'b1;
      for (int i = 0; i < 40; i++) begin
         a = DW'($urandom);
         if ($urandom_range(0, 7) == 0) a = DW'(32'h200_0000);
         case ($urandom_range(0, 5))
            0:       b = '0;
            1:       b = '1;
            2:       b = VW'($urandom_range(1, 5));
            default: b = VW'($urandom);
         endcase
         s = 1'($urandom_range(0, 1));
         issue(a, b, s);
      end
      wait_drain();
      bp_rand = 1'b0;

      repeat (3) @(negedge clk);
      chk("final_scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
